// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-line-RAM arbiter: widths, FSM encoding,
// requester identifiers and a small saturating-counter helper.
package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;   // 16-byte lines

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_WAIT  = 3'd2;
  localparam logic [2:0] ST_WB_ISSUE = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    RD_ISSUE = ST_RD_ISSUE,
    RD_WAIT  = ST_RD_WAIT,
    WB_ISSUE = ST_WB_ISSUE,
    RESP     = ST_RESP
  } state_e;

  // Requester identifiers; also the bit positions in the arbiter req/gnt vectors
  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  // 8-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the requester that did not win
// last time is granted; the last-grant register only moves when advance_i is
// high and something was granted.
module rr_arb2
  import cache_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // One-hot grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ICACHE] && req_i[DCACHE]) begin
      gnt_o = (last_q == DCACHE) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  // Remember the last winner; reset favours Icache on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= DCACHE;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[DCACHE] ? DCACHE : ICACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises Icache refills, Dcache refills and Dcache writebacks onto one
// line-wide RAM port. Addresses/data are latched at grant and held for the
// whole transfer; read data and completion pulses are routed back to the
// winner. Reads that never see ram_ready_i are released after TIMEOUT cycles
// with zero data and a sticky error flag.
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int LINE_W  = cache_pkg::LINE_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_rd_req_i,
  input  logic [ADDR_W-1:0] icache_rd_addr_i,
  output logic [LINE_W-1:0] icache_data_o,
  output logic              icache_ready_o,
  input  logic              dcache_rd_req_i,
  input  logic [ADDR_W-1:0] dcache_rd_addr_i,
  input  logic              dcache_wb_req_i,
  input  logic [ADDR_W-1:0] dcache_wb_addr_i,
  input  logic [LINE_W-1:0] dcache_wb_data_i,
  output logic [LINE_W-1:0] dcache_data_o,
  output logic              dcache_ready_o,
  output logic              ram_rd_req_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  output logic              ram_wb_req_o,
  output logic [ADDR_W-1:0] ram_wb_addr_o,
  output logic [LINE_W-1:0] ram_wb_data_o,
  input  logic [LINE_W-1:0] ram_data_i,
  input  logic              ram_ready_i,
  output logic              timeout_err_o
);

  localparam logic [7:0]        TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  state_e            state_q;
  logic              owner_q;
  logic [7:0]        wait_cnt_q;
  logic [7:0]        wait_cnt_d;
  logic              ram_rd_req_q;
  logic              ram_wb_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [LINE_W-1:0] wb_data_q;
  logic [LINE_W-1:0] icache_data_q;
  logic [LINE_W-1:0] dcache_data_q;
  logic              icache_ready_q;
  logic              dcache_ready_q;
  logic              timeout_err_q;

  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              arb_advance;

  assign arb_req[ICACHE] = icache_rd_req_i;
  assign arb_req[DCACHE] = dcache_wb_req_i | dcache_rd_req_i;
  assign arb_advance     = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .advance_i (arb_advance),
    .gnt_o     (arb_gnt)
  );

  // Saturating next value of the RAM wait counter
  always_comb begin
    wait_cnt_d = sat_inc8(wait_cnt_q);
  end

  // Transfer sequencer; every output is a register written on state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= ICACHE;
      wait_cnt_q     <= '0;
      ram_rd_req_q   <= 1'b0;
      ram_wb_req_q   <= 1'b0;
      rd_addr_q      <= '0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      icache_data_q  <= '0;
      dcache_data_q  <= '0;
      icache_ready_q <= 1'b0;
      dcache_ready_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      // strobes and completion pulses are single-cycle by default
      ram_rd_req_q   <= 1'b0;
      ram_wb_req_q   <= 1'b0;
      icache_ready_q <= 1'b0;
      dcache_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_gnt[DCACHE]) begin
            owner_q <= DCACHE;
            // a pending writeback always goes before the Dcache refill
            if (dcache_wb_req_i) begin
              wb_addr_q    <= dcache_wb_addr_i & ALIGN_MASK;
              wb_data_q    <= dcache_wb_data_i;
              ram_wb_req_q <= 1'b1;
              state_q      <= WB_ISSUE;
            end else begin
              rd_addr_q    <= dcache_rd_addr_i & ALIGN_MASK;
              ram_rd_req_q <= 1'b1;
              state_q      <= RD_ISSUE;
            end
          end else if (arb_gnt[ICACHE]) begin
            owner_q      <= ICACHE;
            rd_addr_q    <= icache_rd_addr_i & ALIGN_MASK;
            ram_rd_req_q <= 1'b1;
            state_q      <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ram_ready_i) begin
            if (owner_q == DCACHE) begin
              dcache_data_q  <= ram_data_i;
              dcache_ready_q <= 1'b1;
            end else begin
              icache_data_q  <= ram_data_i;
              icache_ready_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            // give up: release the requester with a zero line
            if (wait_cnt_d == TIMEOUT_C) begin
              timeout_err_q <= 1'b1;
              if (owner_q == DCACHE) begin
                dcache_data_q  <= '0;
                dcache_ready_q <= 1'b1;
              end else begin
                icache_data_q  <= '0;
                icache_ready_q <= 1'b1;
              end
              state_q <= RESP;
            end
          end
        end
        WB_ISSUE: begin
          // the RAM completes writes in the strobe cycle, so acknowledge now
          dcache_ready_q <= 1'b1;
          state_q        <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram_rd_req_o   = ram_rd_req_q;
  assign ram_rd_addr_o  = rd_addr_q;
  assign ram_wb_req_o   = ram_wb_req_q;
  assign ram_wb_addr_o  = wb_addr_q;
  assign ram_wb_data_o  = wb_data_q;
  assign icache_data_o  = icache_data_q;
  assign icache_ready_o = icache_ready_q;
  assign dcache_data_o  = dcache_data_q;
  assign dcache_ready_o = dcache_ready_q;
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural line RAM, followed by a
// randomized traffic phase checked against a reference memory.
module tb_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         icache_rd_req;
  logic [31:0]  icache_rd_addr;
  logic [127:0] icache_data;
  logic         icache_ready;
  logic         dcache_rd_req;
  logic [31:0]  dcache_rd_addr;
  logic         dcache_wb_req;
  logic [31:0]  dcache_wb_addr;
  logic [127:0] dcache_wb_data;
  logic [127:0] dcache_data;
  logic         dcache_ready;
  logic         ram_rd_req;
  logic [31:0]  ram_rd_addr;
  logic         ram_wb_req;
  logic [31:0]  ram_wb_addr;
  logic [127:0] ram_wb_data;
  logic [127:0] ram_data;
  logic         ram_ready;
  logic         timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .icache_rd_req_i  (icache_rd_req),
    .icache_rd_addr_i (icache_rd_addr),
    .icache_data_o    (icache_data),
    .icache_ready_o   (icache_ready),
    .dcache_rd_req_i  (dcache_rd_req),
    .dcache_rd_addr_i (dcache_rd_addr),
    .dcache_wb_req_i  (dcache_wb_req),
    .dcache_wb_addr_i (dcache_wb_addr),
    .dcache_wb_data_i (dcache_wb_data),
    .dcache_data_o    (dcache_data),
    .dcache_ready_o   (dcache_ready),
    .ram_rd_req_o     (ram_rd_req),
    .ram_rd_addr_o    (ram_rd_addr),
    .ram_wb_req_o     (ram_wb_req),
    .ram_wb_addr_o    (ram_wb_addr),
    .ram_wb_data_o    (ram_wb_data),
    .ram_data_i       (ram_data),
    .ram_ready_i      (ram_ready),
    .timeout_err_o    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural line RAM (256 lines) ----------------
  logic [127:0] mem [0:255];
  logic [255:0] written = '0;
  logic         ram_stall = 1'b0;
  logic         rnd_lat = 1'b0;
  logic         force_ready = 1'b0;
  logic         ready_m = 1'b0;
  logic [127:0] data_m = '0;
  logic         pend = 1'b0;
  logic [1:0]   dly = '0;
  logic [31:0]  pend_addr = '0;

  // power-up contents: byte j of line idx holds (idx*16 + j) mod 256
  function automatic logic [127:0] init_line(input logic [7:0] idx);
    logic [127:0] l;
    for (int j = 0; j < 16; j++) l[j*8 +: 8] = 8'(32'(idx) * 16 + j);
    return l;
  endfunction

  function automatic logic [127:0] ram_line(input logic [31:0] a);
    return written[a[11:4]] ? mem[a[11:4]] : init_line(a[11:4]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_m <= 1'b0;
      pend    <= 1'b0;
    end else begin
      ready_m <= 1'b0;
      if (ram_wb_req) begin
        mem[ram_wb_addr[11:4]]     <= ram_wb_data;
        written[ram_wb_addr[11:4]] <= 1'b1;
      end
      if (ram_rd_req) begin
        if (!ram_stall && !(rnd_lat && $urandom_range(0, 1) == 1)) begin
          ready_m <= 1'b1;
          data_m  <= ram_line(ram_rd_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= ram_rd_addr;
          dly       <= 2'($urandom_range(1, 3));
        end
      end else if (pend && !ram_stall) begin
        if (dly <= 2'd1) begin
          ready_m <= 1'b1;
          data_m  <= ram_line(pend_addr);
          pend    <= 1'b0;
        end else begin
          dly <= dly - 2'd1;
        end
      end
    end
  end

  assign ram_ready = ready_m | force_ready;
  assign ram_data  = data_m;

  int d_ready_cnt = 0;
  always @(negedge clk) if (dcache_ready) d_ready_cnt <= d_ready_cnt + 1;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] L100 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] L040 = 128'h4F4E4D4C_4B4A4948_47464544_43424140;
  localparam logic [127:0] L080 = 128'h8F8E8D8C_8B8A8988_87868584_83828180;
  localparam logic [127:0] L0C0 = 128'hCFCECDCC_CBCAC9C8_C7C6C5C4_C3C2C1C0;
  localparam logic [127:0] LAA  = {16{8'hAA}};

  // reference memory for the random phase
  logic [127:0] ref_mem [0:255];
  logic [255:0] ref_wr = '0;

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    return ref_wr[a[11:4]] ? ref_mem[a[11:4]] : init_line(a[11:4]);
  endfunction

  initial begin
    int base;
    int i_age, d_age, i_max, d_max, i_done, d_done;
    icache_rd_req = 0; icache_rd_addr = 0;
    dcache_rd_req = 0; dcache_rd_addr = 0;
    dcache_wb_req = 0; dcache_wb_addr = 0; dcache_wb_data = 0;
    rst_n = 1'b0;
    tick(2);

    // reset state
    check("rst_i_ready", icache_ready, 0);
    check("rst_d_ready", dcache_ready, 0);
    check("rst_rd_req", ram_rd_req, 0);
    check("rst_wb_req", ram_wb_req, 0);
    check("rst_err", timeout_err, 0);
    check("rst_i_data", icache_data, 0);
    rst_n = 1'b1;
    tick(1);

    // ---- 1: single Icache refill, unaligned address ----
    icache_rd_req = 1; icache_rd_addr = 32'h0000_0107;
    tick(1);
    check("t1_rd_req", ram_rd_req, 1);
    check("t1_rd_addr", ram_rd_addr, 32'h100);
    tick(1);
    check("t1_rd_req_low", ram_rd_req, 0);
    check("t1_addr_hold", ram_rd_addr, 32'h100);
    check("t1_no_ready_yet", icache_ready, 0);
    tick(1);
    check("t1_i_ready", icache_ready, 1);
    check("t1_i_data", icache_data, L100);
    $display("T1 icache read 0x107 -> ready=%0b data=%h", icache_ready, icache_data);
    tick(1);
    icache_rd_req = 0;
    check("t1_pulse_one", icache_ready, 0);

    // ---- 2: simultaneous refills after reset, then held ----
    do_reset();
    icache_rd_req = 1; icache_rd_addr = 32'h040;
    dcache_rd_req = 1; dcache_rd_addr = 32'h080;
    tick(3);
    check("t2_first_i", icache_ready, 1);
    check("t2_first_not_d", dcache_ready, 0);
    check("t2_i_data", icache_data, L040);
    tick(1);
    icache_rd_req = 0;
    tick(3);
    check("t2_second_d", dcache_ready, 1);
    check("t2_second_not_i", icache_ready, 0);
    check("t2_d_data", dcache_data, L080);
    tick(1);
    icache_rd_req = 1;
    for (int k = 0; k < 4; k++) begin
      tick(3);
      check($sformatf("t2_alt%0d_i", k), icache_ready, 1'((k % 2) == 0));
      check($sformatf("t2_alt%0d_d", k), dcache_ready, 1'((k % 2) == 1));
      $display("T2 grant %0d: i_ready=%0b d_ready=%0b", k, icache_ready, dcache_ready);
      tick(1);
    end
    icache_rd_req = 0; dcache_rd_req = 0;

    // ---- 3: writeback before refill to the same line ----
    base = d_ready_cnt;
    dcache_wb_req = 1; dcache_wb_addr = 32'h20F; dcache_wb_data = LAA;
    dcache_rd_req = 1; dcache_rd_addr = 32'h203;
    tick(1);
    check("t3_wb_req", ram_wb_req, 1);
    check("t3_no_rd", ram_rd_req, 0);
    check("t3_wb_addr", ram_wb_addr, 32'h200);
    check("t3_wb_data", ram_wb_data, LAA);
    tick(1);
    check("t3_wb_ack", dcache_ready, 1);
    tick(1);
    dcache_wb_req = 0;
    tick(1);
    check("t3_rd_req", ram_rd_req, 1);
    check("t3_rd_addr", ram_rd_addr, 32'h200);
    tick(2);
    check("t3_rd_ready", dcache_ready, 1);
    check("t3_rd_data", dcache_data, LAA);
    $display("T3 read-after-writeback 0x200 -> data=%h", dcache_data);
    tick(1);
    dcache_rd_req = 0;
    tick(5);
    check("t3_two_pulses", 128'(d_ready_cnt - base), 2);

    // ---- 4: RAM never answers -> timeout ----
    ram_stall = 1;
    icache_rd_req = 1; icache_rd_addr = 32'h300;
    tick(1);
    check("t4_rd_issue", ram_rd_req, 1);
    tick(15);
    check("t4_err_not_yet", timeout_err, 0);
    check("t4_ready_not_yet", icache_ready, 0);
    tick(1);
    check("t4_err_set", timeout_err, 1);
    check("t4_ready", icache_ready, 1);
    check("t4_zero_data", icache_data, 0);
    $display("T4 timeout -> err=%0b ready=%0b data=%h", timeout_err, icache_ready, icache_data);
    tick(1);
    icache_rd_req = 0;
    tick(5);
    check("t4_err_sticky", timeout_err, 1);

    // ---- 5: reset during RD_WAIT ----
    icache_rd_req = 1; icache_rd_addr = 32'h0D0;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    icache_rd_req = 0;
    check("t5_rst_err", timeout_err, 0);
    check("t5_rst_rd_addr", ram_rd_addr, 0);
    check("t5_rst_wb_addr", ram_wb_addr, 0);
    check("t5_rst_wb_data", ram_wb_data, 0);
    check("t5_rst_d_data", dcache_data, 0);
    check("t5_rst_ready", icache_ready, 0);
    tick(2);
    rst_n = 1'b1;
    ram_stall = 0;
    force_ready = 1;
    tick(1);
    force_ready = 0;
    check("t5_no_pulse_i", icache_ready, 0);
    check("t5_no_pulse_d", dcache_ready, 0);
    tick(3);
    check("t5_still_quiet", icache_ready, 0);
    icache_rd_req = 1; icache_rd_addr = 32'h0C5;
    tick(3);
    check("t5_new_ready", icache_ready, 1);
    check("t5_new_data", icache_data, L0C0);
    $display("T5 post-reset read 0xC5 -> ready=%0b data=%h", icache_ready, icache_data);
    tick(1);
    icache_rd_req = 0;

    // ---- 6: random traffic on lines 0x40..0x47 ----
    rnd_lat = 1;
    i_age = 0; d_age = 0; i_max = 0; d_max = 0; i_done = 0; d_done = 0;
    for (int c = 0; c < 10000; c++) begin
      tick(1);
      check("r_strobe_excl", 128'(ram_rd_req & ram_wb_req), 0);
      check("r_ready_excl", 128'(icache_ready & dcache_ready), 0);
      if (icache_ready) begin
        check("r_i_spurious", 128'(icache_rd_req), 1);
        check("r_i_data", icache_data, ref_line(icache_rd_addr));
        icache_rd_req = 0; i_age = 0; i_done++;
      end else if (icache_rd_req) begin
        i_age++;
        if (i_age > i_max) i_max = i_age;
      end else if ($urandom_range(0, 3) == 0) begin
        icache_rd_req = 1; icache_rd_addr = 32'h400 + $urandom_range(0, 127);
      end
      if (dcache_ready) begin
        check("r_d_spurious", 128'(dcache_wb_req | dcache_rd_req), 1);
        if (dcache_wb_req) begin
          ref_mem[dcache_wb_addr[11:4]] = dcache_wb_data;
          ref_wr[dcache_wb_addr[11:4]]  = 1'b1;
          dcache_wb_req = 0;
        end else begin
          check("r_d_data", dcache_data, ref_line(dcache_rd_addr));
          dcache_rd_req = 0;
        end
        d_age = 0; d_done++;
      end else if (dcache_wb_req || dcache_rd_req) begin
        d_age++;
        if (d_age > d_max) d_max = d_age;
      end else begin
        case ($urandom_range(0, 7))
          0: begin
            dcache_wb_req = 1; dcache_wb_addr = 32'h400 + $urandom_range(0, 127);
            dcache_wb_data = {$urandom, $urandom, $urandom, $urandom};
          end
          1: begin
            dcache_rd_req = 1; dcache_rd_addr = 32'h400 + $urandom_range(0, 127);
          end
          2: begin
            dcache_wb_req = 1; dcache_wb_addr = 32'h400 + $urandom_range(0, 127);
            dcache_wb_data = {$urandom, $urandom, $urandom, $urandom};
            dcache_rd_req = 1; dcache_rd_addr = 32'h400 + $urandom_range(0, 127);
          end
          default: ;
        endcase
      end
    end
    $display("T6 random: %0d icache and %0d dcache completions, max wait %0d/%0d", i_done, d_done, i_max, d_max);
    check("r_i_bounded_wait", 128'(i_max < 40), 1);
    check("r_d_bounded_wait", 128'(d_max < 40), 1);
    check("r_i_progress", 128'(i_done > 100), 1);
    check("r_d_progress", 128'(d_done > 100), 1);
    check("r_no_timeout", timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the two L1 caches (Icache refill port, Dcache refill and writeback ports) and the single 128-bit line RAM.
- Serialises all line transfers onto the one RAM port and holds addresses and data stable for the whole transaction.
- Returns refill data to the requester that won arbitration, and generates write acknowledges, which the RAM does not provide.
- Arbitration is round-robin between Icache and Dcache. Within Dcache, a writeback always goes before a refill.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width in bits (16 bytes).
- TIMEOUT, 15, maximum cycles to wait for ram_ready_i before flagging an error; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_rd_req_i  in  1  Icache refill request; level, held until icache_ready_o.
- icache_rd_addr_i  in  ADDR_W  Icache refill address.
- icache_data_o  out  LINE_W  refill line to Icache.
- icache_ready_o  out  1  one-cycle completion pulse to Icache.
- dcache_rd_req_i  in  1  Dcache refill request; level, held until dcache_ready_o.
- dcache_rd_addr_i  in  ADDR_W  Dcache refill address.
- dcache_wb_req_i  in  1  Dcache writeback request; level, held until dcache_ready_o.
- dcache_wb_addr_i  in  ADDR_W  writeback address.
- dcache_wb_data_i  in  LINE_W  writeback line.
- dcache_data_o  out  LINE_W  refill line to Dcache.
- dcache_ready_o  out  1  one-cycle completion pulse for a Dcache refill or writeback.
- ram_rd_req_o  out  1  RAM read strobe.
- ram_rd_addr_o  out  ADDR_W  RAM read address.
- ram_wb_req_o  out  1  RAM write strobe.
- ram_wb_addr_o  out  ADDR_W  RAM write address.
- ram_wb_data_o  out  LINE_W  RAM write data.
- ram_data_i  in  LINE_W  RAM read data.
- ram_ready_i  in  1  RAM read-data valid.
- timeout_err_o  out  1  sticky; set on RAM read timeout, cleared only by reset.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, rr_last = DCACHE (so Icache wins the first tie). Reset mid-transaction aborts it; no ready pulse is produced afterwards.
- Addresses are captured at grant with the low 4 bits forced to 0, so every transfer is line-aligned. Write data is captured at grant. Requester inputs are ignored until the next IDLE.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WB_ISSUE, RESP.
- Grant in IDLE:
  - Candidates: I = icache_rd_req_i; D = dcache_wb_req_i | dcache_rd_req_i.
  - Only one candidate: it wins.
  - Both candidates: the one not equal to rr_last wins; rr_last is updated on grant.
  - Dcache granted with both wb and rd high: writeback is serviced. The refill stays pending and competes again next IDLE.
- IDLE -> RD_ISSUE (read grant) or WB_ISSUE (writeback grant) on the cycle after grant. No grant: stay in IDLE.
- RD_ISSUE:
  - ram_rd_req_o = 1 for exactly one cycle; ram_rd_addr_o = latched address.
  - Next state RD_WAIT; clear wait counter.
- RD_WAIT:
  - ram_rd_req_o = 0; ram_rd_addr_o holds its value.
  - On ram_ready_i = 1: capture ram_data_i into the winner's data output, go to RESP.
  - Each cycle without ready increments the counter. When counter == TIMEOUT: set timeout_err_o, drive data 0, go to RESP (the requester is still released).
- WB_ISSUE:
  - ram_wb_req_o = 1 for one cycle, with address and data stable; next state RESP.
  - RAM writes complete in that cycle, so no wait state is needed.
- RESP:
  - Pulse the winner's ready for one cycle; the data output is valid in the same cycle.
  - Next state IDLE.
  - The data output holds until the next capture into it. The ready pulse is the only qualifier.
- Latencies from request visible in IDLE to ready pulse:
  - Writeback: 3 cycles.
  - Read with the RAM's 1-cycle ready: 4 cycles.
- Requesters deassert req in the cycle after ready. If a req is still high in IDLE, it is treated as a new request.
- ram_rd_req_o and ram_wb_req_o are never high together. At most one ready output is high in any cycle.
- The wait counter is 8 bits and saturates; it does not wrap.

Decomposition:
- Shared package cache_pkg:
  - LINE_W, ADDR_W, and the line-offset width (4).
  - FSM state encoding as localparams.
  - Requester ID constants ICACHE = 1'b0, DCACHE = 1'b1.
- Sub-module rr_arb2: two-requester round-robin arbiter with last-grant register. Inputs: req[1:0], advance. Outputs: one-hot gnt.
- Everything else is in mem_arbiter.

Test Plan:
1. Icache only, addr 0x0000_0107, RAM preloaded 0x0F0E..0100 at 0x100 -> ram_rd_addr_o = 0x100; icache_ready_o pulses in cycle 4 with icache_data_o = 0x0F0E0D0C_0B0A0908_07060504_03020100.
2. Icache and Dcache refill raised in the same cycle after reset -> Icache served first, Dcache second. Repeat with both held -> grants alternate I, D, I, D.
3. dcache_wb_req_i and dcache_rd_req_i both high to the same line 0x200, wb data 0xAA..AA -> write issued first; the following read returns 0xAA..AA; exactly two dcache_ready_o pulses.
4. RAM model never asserts ready, TIMEOUT = 15 -> timeout_err_o rises 16 cycles after RD_ISSUE; ready pulses with data 0; the flag stays set until rst_n is low.
5. rst_n asserted in RD_WAIT -> all outputs 0 immediately. A ram_ready_i arriving afterwards produces no ready pulse. A new request after reset completes normally.
6. Random I/D/wb traffic, 10k cycles, against a reference memory model -> no read/write strobe overlap, at most one ready per cycle, all read data matches the model.
